shift_add_mult4: RTL and testbench
==================================

SHIFT_ADD_MULT4 -- requirements
Module: shift_add_mult4

Interface
REQ-001 SHALL have no parameters; operand width fixed at 4 bits, product width 8 bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port: inA  input  4  multiplicand, unsigned; latched on accepted start.
REQ-006 SHALL have port: inB  input  4  multiplier, unsigned; latched on accepted start.
REQ-007 SHALL have port: busy  output  1  high while in CALC or DONE.
REQ-008 SHALL have port: done  output  1  one-cycle pulse; product valid.
REQ-009 SHALL have port: product  output  8  unsigned result inA*inB.

Function
REQ-010 SHALL implement FSM states IDLE, CALC, DONE; no other reachable states.
REQ-011 SHALL, in IDLE with start=1 at edge N: latch M=inA, Q=inB, clear acc[3:0], set step counter to 0, and enter CALC.
REQ-012 SHALL, in IDLE with start=0, remain in IDLE with all registers held.
REQ-013 SHALL perform one add-shift step per CALC cycle: if Q[0]=1, {c,s}=acc+M with carryIn=0, else {c,s}={0,acc}; then {acc,Q} <= {c,s,Q}>>1.
REQ-014 SHALL perform exactly 4 steps (edges N+1..N+4); on edge N+4 enter DONE.
REQ-015 SHALL drive done=1 during the DONE cycle only (after edge N+4, before edge N+5); latency start-to-done = 5 edges.
REQ-016 SHALL return from DONE to IDLE unconditionally on the next edge.
REQ-017 SHALL present product={acc,Q} and hold it stable from DONE until the next accepted start.
REQ-018 SHALL ignore start, inA and inB while in CALC or DONE; the in-flight operation is unaffected.
REQ-019 SHALL accept a start asserted in the first IDLE cycle after DONE (back-to-back, 6-cycle throughput).
REQ-020 SHALL never overflow: the 8-bit product covers 15*15=225; adder carry-out is the 5th bit before shift.
REQ-021 SHALL keep busy=0 and done=0 in IDLE.

Reset
REQ-022 SHALL, when reset=1 at a rising edge, force state=IDLE, acc=0, Q=0, M=0, counter=0, irrespective of current state.
REQ-023 SHALL drive busy=0, done=0, product=8'h00 after reset.
REQ-024 SHALL abort an operation in progress on reset; no done pulse for it.
REQ-025 SHALL give reset priority over start on the same edge.

Structure
REQ-026 SHALL take state encodings (IDLE=2'b00, CALC=2'b01, DONE=2'b10) and step count (4) from a shared definitions header used by all sequencer blocks.
REQ-027 SHALL instantiate exactly one fullAdder4Bits for the accumulate path; no behavioural '+' on the datapath.
REQ-028 SHALL keep the FSM, counter and shift registers in this module; no further sub-modules.

Verification
REQ-029 SHALL cover: reset, start with inA=4'hF, inB=4'hF -> done pulse 5 edges later, product=8'hE1, busy high for 5 cycles.
REQ-030 SHALL cover: inA=4'hD, inB=4'hB -> product=8'h8F; inA=0, inB=4'h9 -> product=8'h00 with normal done timing.
REQ-031 SHALL cover: start held high, inA/inB changed during CALC -> result matches operands latched at accept; no restart until IDLE.
REQ-032 SHALL cover: reset asserted at the 2nd CALC cycle -> next cycle IDLE, product=0, no done pulse.
REQ-033 SHALL cover: back-to-back start (3*5 then 7*6) -> products 8'h0F then 8'h2A, done pulses 6 cycles apart.
REQ-034 SHALL cover: exhaustive 256-pair sweep against a reference model -> all products match.

Source files
------------

// File: rtl/shift_add_mult4_pkg.sv
// Shared definitions for the shift-add multiplier sequencer.
// State encodings and step count live here so all blocks agree.
package shift_add_mult4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } stateT;

  localparam int unsigned STEPS = 4;
  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

endpackage

// File: rtl/shift_add_mult4_adder.sv
// 4-bit ripple-carry adder built from gate-level full-adder cells.
// Used as the sole accumulate path of the multiplier.
module fullAdder4Bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carryIn,
  output logic [3:0] sum,
  output logic       carryOut
);

  logic [4:0] c;

  assign c[0] = carryIn;

  for (genvar i = 0; i < 4; i++) begin : gBit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign carryOut = c[4];

endmodule

// File: rtl/shift_add_mult4.sv
// 4x4 unsigned sequential multiplier: one add-shift step per cycle.
// IDLE -> CALC (4 steps) -> DONE (one-cycle pulse) -> IDLE.
module shift_add_mult4
  import shift_add_mult4_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] inA,
  input  logic [3:0] inB,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);

  stateT state;
  stateT stateNext;

  logic [3:0]       m;
  logic [3:0]       q;
  logic [3:0]       acc;
  logic [CNT_W-1:0] cnt;

  logic [3:0] addend;
  logic [3:0] sum;
  logic       carry;

  logic accept;

  assign accept = (state == IDLE) && start;
  assign addend = q[0] ? m : 4'h0;

  fullAdder4Bits uAdd (
    .a        (acc),
    .b        (addend),
    .carryIn  (1'b0),
    .sum      (sum),
    .carryOut (carry)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) stateNext = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == LAST_STEP) stateNext = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Carry-out becomes the new acc MSB after the right shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      m   <= '0;
      q   <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      m   <= inA;
      q   <= inB;
      acc <= '0;
      cnt <= '0;
    end else if (state == CALC) begin
      acc <= {carry, sum[3:1]};
      q   <= {sum[0], q[3:1]};
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign product = {acc, q};

endmodule

// File: tb/tb_shift_add_mult4.sv
// Self-checking bench for shift_add_mult4.
// Expected products come from plain a*b arithmetic.
module tb_shift_add_mult4;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] inA;
  logic [3:0] inB;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lastDoneCyc;

  shift_add_mult4 dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .inA     (inA),
    .inB     (inB),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
    bit         hold;
  } vecT;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after DONE.
  task automatic runOp(input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] exp, input bit hold);
    int lat;
    int busyCnt;
    start = 1'b1;
    inA   = a;
    inB   = b;
    @(negedge clk);
    if (!hold) start = 1'b0;
    busyCnt = busy ? 1 : 0;
    lat = 0;
    while (!done && lat < 20) begin
      if (hold) begin
        inA = 4'($urandom);
        inB = 4'($urandom);
      end
      @(negedge clk);
      lat++;
      if (busy) busyCnt++;
    end
    lastDoneCyc = cyc;
    check("latency", lat, 4);
    check("busyCycles", busyCnt, 5);
    check("product", int'(product), int'(exp));
    if (hold) begin
      inA = 4'($urandom);
      inB = 4'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    check("idleBusy", int'(busy), 0);
    check("idleDone", int'(done), 0);
    check("heldProduct", int'(product), int'(exp));
  endtask

  vecT vecs[$];

  initial begin
    int firstDone;
    int a;
    int b;
    logic [7:0] e;

    vecs.push_back('{4'hF, 4'hF, 8'hE1, 1'b0});
    vecs.push_back('{4'hD, 4'hB, 8'h8F, 1'b0});
    vecs.push_back('{4'h0, 4'h9, 8'h00, 1'b0});
    vecs.push_back('{4'h3, 4'h5, 8'h0F, 1'b1});
    vecs.push_back('{4'h7, 4'h6, 8'h2A, 1'b0});
    vecs.push_back('{4'h1, 4'hF, 8'h0F, 1'b0});
    vecs.push_back('{4'hF, 4'h1, 8'h0F, 1'b1});
    vecs.push_back('{4'hF, 4'h0, 8'h00, 1'b0});
    vecs.push_back('{4'h8, 4'h8, 8'h40, 1'b0});

    reset = 1'b1;
    start = 1'b1;
    inA   = 4'hF;
    inB   = 4'hF;
    repeat (3) @(negedge clk);
    check("rstBusy", int'(busy), 0);
    check("rstDone", int'(done), 0);
    check("rstProduct", int'(product), 0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("idleNoStart", int'(busy), 0);

    foreach (vecs[i]) runOp(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold);

    // back-to-back operations
    runOp(4'h3, 4'h5, 8'h0F, 1'b0);
    firstDone = lastDoneCyc;
    runOp(4'h7, 4'h6, 8'h2A, 1'b0);
    check("doneSpacing", lastDoneCyc - firstDone, 6);

    // reset during the second CALC cycle aborts the operation
    start = 1'b1;
    inA   = 4'hF;
    inB   = 4'hF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("midBusy", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abortBusy", int'(busy), 0);
    check("abortProduct", int'(product), 0);
    begin
      int pulses = 0;
      for (int k = 0; k < 8; k++) begin
        if (done) pulses++;
        @(negedge clk);
      end
      check("abortNoDone", pulses, 0);
    end

    // exhaustive sweep
    for (int i = 0; i < 256; i++) begin
      a = i / 16;
      b = i % 16;
      e = 8'(a * b);
      runOp(4'(a), 4'(b), e, 1'b0);
    end

    // random operands, sometimes holding start and scrambling inputs
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(15, 0));
      b = int'($urandom_range(15, 0));
      e = 8'(a * b);
      runOp(4'(a), 4'(b), e, bit'($urandom_range(1, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
